// File: rtl/pwm_duty_slew_limiter.sv
// ---------------------------------------------------------------------------
// pwm_duty_slew_limiter
//
// Sits between the SPI register bank and the PWM generator and rate-limits
// the applied duty cycle. The raw target is registered once, and the applied
// duty (duty_out) then walks toward it by STEP codes every PRESCALE clocks.
// This stops a large SPI write from slamming the PWM outputs. Setting bypass
// makes duty_out follow the registered target directly.
//
// Optional feature macro: DUTY_SLEW_SETTLE_PULSE_EN
//   Defined     : the settle_pulse output exists. It is a 1-clock pulse when a
//                 ramp completes, either on the final step or when the target
//                 becomes equal to the current duty.
//   Not defined : the settle_pulse port and its logic are not built.
//                 duty_out and busy behave the same in both builds.
// ---------------------------------------------------------------------------
module pwm_duty_slew_limiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 256,
    parameter int unsigned STEP     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] target_duty,
    input  logic             bypass,
    output logic [WIDTH-1:0] duty_out,
    output logic             busy
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
    ,
    output logic             settle_pulse
`endif
);

    // Prescale counter width. It is at least 1 bit, so PRESCALE=1 still builds.
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PRESCALE - 1);
    // The step size is held one bit wider than the duty, so step sums and
    // differences cannot wrap.
    localparam logic [WIDTH:0] STEP_W   = (WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] duty_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [WIDTH-1:0] duty_d;
    logic             term_s;
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
    logic             settle_q;
`endif

    // Upward step. The result saturates at the target, so it never overshoots
    // and never passes the all-ones code.
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] sum;
        sum = {1'b0, cur} + STEP_W;
        if (sum >= {1'b0, tgt}) begin
            return tgt;
        end else begin
            return sum[WIDTH-1:0];
        end
    endfunction

    // Downward step. A borrow counts as underflow, and the result clamps to
    // the target.
    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] diff;
        diff = {1'b0, cur} - STEP_W;
        if (diff[WIDTH] || (diff[WIDTH-1:0] <= tgt)) begin
            return tgt;
        end else begin
            return diff[WIDTH-1:0];
        end
    endfunction

    // Candidate duty for the next step in the current ramp direction.
    always_comb begin
        duty_d = duty_q;
        case (state_q)
            ST_UP:   duty_d = step_up(duty_q, target_q);
            ST_DOWN: duty_d = step_down(duty_q, target_q);
            default: duty_d = duty_q;
        endcase
    end

    // Terminal count of the prescaler.
    always_comb begin
        if (cnt_q == CNT_LAST) begin
            term_s = 1'b1;
        end else begin
            term_s = 1'b0;
        end
    end

    // Input register, ramp FSM, prescaler and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= {WIDTH{1'b0}};
            duty_q   <= {WIDTH{1'b0}};
            cnt_q    <= CNT_ZERO;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
            settle_q <= 1'b0;
`endif
        end else begin
            target_q <= target_duty;
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
            settle_q <= 1'b0;
`endif
            if (bypass) begin
                // Unlimited mode. Stay IDLE so that clearing bypass resumes
                // from this value without a jump.
                duty_q  <= target_q;
                cnt_q   <= CNT_ZERO;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if (target_q == duty_q) begin
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
                if (state_q != ST_IDLE) begin
                    settle_q <= 1'b1;
                end else begin
                    settle_q <= 1'b0;
                end
`endif
                cnt_q   <= CNT_ZERO;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if ((target_q > duty_q) && (state_q != ST_UP)) begin
                // Starting a ramp, or reversing direction. Restart the
                // prescaler so that a full interval passes before the first
                // step.
                cnt_q   <= CNT_ZERO;
                state_q <= ST_UP;
                busy_q  <= 1'b1;
            end else if ((target_q < duty_q) && (state_q != ST_DOWN)) begin
                cnt_q   <= CNT_ZERO;
                state_q <= ST_DOWN;
                busy_q  <= 1'b1;
            end else if (term_s) begin
                // Step toward the target. If this step lands on the target,
                // the ramp ends on this same edge.
                cnt_q  <= CNT_ZERO;
                duty_q <= duty_d;
                if (duty_d == target_q) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
                    settle_q <= 1'b1;
`endif
                end else begin
                    state_q <= state_q;
                    busy_q  <= 1'b1;
                end
            end else begin
                // Mid-ramp in the same direction. Keep counting. A target
                // change in the same direction does not restart the count.
                cnt_q   <= cnt_q + CNT_ONE;
                state_q <= state_q;
                busy_q  <= 1'b1;
            end
        end
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
    assign settle_pulse = settle_q;
`endif

endmodule

// File: tb/tb_pwm_duty_slew_limiter.sv
// ---------------------------------------------------------------------------
// Testbench for pwm_duty_slew_limiter. It uses two instances:
//   dut_a : PRESCALE=4, STEP=1
//   dut_b : PRESCALE=4, STEP=100
// The stimulus process pushes each expected duty_out change (value and the
// clock edge index on which it lands) into a queue per instance. A monitor
// pops one entry every time that instance's duty_out changes and compares
// it. Level checks on busy and settle_pulse are made directly by the
// stimulus process.
// ---------------------------------------------------------------------------
module tb_pwm_duty_slew_limiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tgt_a, tgt_b;
    logic       byp_a, byp_b;
    logic [7:0] duty_a, duty_b;
    logic       busy_a, busy_b;
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
    logic       settle_a, settle_b;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [7:0] duty;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pwm_duty_slew_limiter #(.WIDTH(8), .PRESCALE(4), .STEP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .target_duty(tgt_a), .bypass(byp_a),
        .duty_out(duty_a), .busy(busy_a)
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
        , .settle_pulse(settle_a)
`endif
    );

    pwm_duty_slew_limiter #(.WIDTH(8), .PRESCALE(4), .STEP(100)) dut_b (
        .clk(clk), .rst_n(rst_n), .target_duty(tgt_b), .bypass(byp_b),
        .duty_out(duty_b), .busy(busy_b)
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
        , .settle_pulse(settle_b)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input int c, input int d);
        ev_t e;
        e.cyc  = c;
        e.duty = 8'(d);
        q_a.push_back(e);
    endtask

    task automatic push_b(input int c, input int d);
        ev_t e;
        e.cyc  = c;
        e.duty = 8'(d);
        q_b.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    logic [7:0] prev_a = 8'd0;
    logic [7:0] prev_b = 8'd0;

    // Monitor for dut_a: each duty_out change must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (duty_a !== prev_a) begin
            checks++;
            if (q_a.size() == 0) begin
                failures++;
                $display("FAIL duty_a_unexpected: got %0d at cycle %0d, no change expected", duty_a, cyc);
            end else begin
                e = q_a.pop_front();
                if ((e.duty !== duty_a) || (e.cyc != cyc)) begin
                    failures++;
                    $display("FAIL duty_a_event: got %0d at cycle %0d expected %0d at cycle %0d",
                             duty_a, cyc, e.duty, e.cyc);
                end
            end
            prev_a = duty_a;
        end
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        ev_t e;
        if (duty_b !== prev_b) begin
            checks++;
            if (q_b.size() == 0) begin
                failures++;
                $display("FAIL duty_b_unexpected: got %0d at cycle %0d, no change expected", duty_b, cyc);
            end else begin
                e = q_b.pop_front();
                if ((e.duty !== duty_b) || (e.cyc != cyc)) begin
                    failures++;
                    $display("FAIL duty_b_event: got %0d at cycle %0d expected %0d at cycle %0d",
                             duty_b, cyc, e.duty, e.cyc);
                end
            end
            prev_b = duty_b;
        end
    end

    // Absolute watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t0, t1;
        rst_n = 1'b0;
        tgt_a = 8'd0;
        tgt_b = 8'd0;
        byp_a = 1'b0;
        byp_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1. Reset state, then idle for 20 clocks with the target held at 0.
        check("reset_duty_a", duty_a, 0);
        check("reset_busy_a", busy_a, 0);
        check("reset_duty_b", duty_b, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy_a", busy_a, 0);
            check("idle_duty_a", duty_a, 0);
        end

        // 2. Ramp 0 -> 10. Duty n lands 2 + 4n edges after the write.
        t0 = cyc;
        tgt_a = 8'd10;
        for (int n = 1; n <= 10; n++) push_a(t0 + 2 + 4 * n, n);
        @(negedge clk);
        check("t2_busy_lat1", busy_a, 0);
        @(negedge clk);
        check("t2_busy_lat2", busy_a, 1);
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
        wait_cyc(t0 + 41);
        check("t2_settle_before", settle_a, 0);
`endif
        wait_cyc(t0 + 42);
        check("t2_duty_final", duty_a, 10);
        check("t2_busy_final", busy_a, 0);
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
        check("t2_settle_pulse", settle_a, 1);
        @(negedge clk);
        check("t2_settle_after", settle_a, 0);
`endif
        repeat (3) @(negedge clk);
        check("t2_busy_idle", busy_a, 0);
        check("t2_events_done", q_a.size(), 0);

        // Use bypass to bring the duty back to 0.
        t = cyc;
        byp_a = 1'b1;
        tgt_a = 8'd0;
        push_a(t + 2, 0);
        wait_cyc(t + 3);
        byp_a = 1'b0;
        check("bypass0_busy", busy_a, 0);

        // 3. Ramping up to 20, the target is rewritten to 2 when the duty is 5.
        t0 = cyc;
        tgt_a = 8'd20;
        for (int n = 1; n <= 5; n++) push_a(t0 + 2 + 4 * n, n);
        wait_cyc(t0 + 22);
        check("t3_duty_at_rev", duty_a, 5);
        tgt_a = 8'd2;
        t1 = cyc;
        for (int m = 1; m <= 3; m++) push_a(t1 + 2 + 4 * m, 5 - m);
        check("t3_busy_ramp", busy_a, 1);
        wait_cyc(t1 + 14);
        check("t3_duty_final", duty_a, 2);
        check("t3_busy_final", busy_a, 0);
        repeat (2) @(negedge clk);
        check("t3_events_done", q_a.size(), 0);

        // 6. Start at 18 and ramp to 50. At duty 20 the target becomes 60.
        //    The step spacing must not change.
        t = cyc;
        byp_a = 1'b1;
        tgt_a = 8'd18;
        push_a(t + 2, 18);
        wait_cyc(t + 3);
        byp_a = 1'b0;
        t0 = cyc;
        tgt_a = 8'd50;
        for (int n = 1; n <= 42; n++) push_a(t0 + 2 + 4 * n, 18 + n);
        wait_cyc(t0 + 10);
        check("t6_duty_at_rewrite", duty_a, 20);
        tgt_a = 8'd60;
        wait_cyc(t0 + 170);
        check("t6_duty_final", duty_a, 60);
        check("t6_busy_final", busy_a, 0);
        repeat (2) @(negedge clk);
        check("t6_events_done", q_a.size(), 0);

        // 5. Bypass jumps to 200. After bypass is cleared with a target of 190,
        //    the duty ramps down from 200.
        t = cyc;
        byp_a = 1'b1;
        tgt_a = 8'd200;
        push_a(t + 2, 200);
        @(negedge clk);
        check("t5_busy_byp1", busy_a, 0);
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
        check("t5_settle_byp1", settle_a, 0);
`endif
        @(negedge clk);
        check("t5_duty_byp", duty_a, 200);
        check("t5_busy_byp2", busy_a, 0);
`ifdef DUTY_SLEW_SETTLE_PULSE_EN
        check("t5_settle_byp2", settle_a, 0);
`endif
        byp_a = 1'b0;
        tgt_a = 8'd190;
        t1 = cyc;
        for (int m = 1; m <= 10; m++) push_a(t1 + 2 + 4 * m, 200 - m);
        @(negedge clk);
        check("t5_no_jump", duty_a, 200);
        wait_cyc(t1 + 42);
        check("t5_duty_final", duty_a, 190);
        check("t5_busy_final", busy_a, 0);
        repeat (2) @(negedge clk);
        check("t5_events_done", q_a.size(), 0);

        // 1b. Asynchronous reset in the middle of a ramp toward 255.
        t0 = cyc;
        tgt_a = 8'd255;
        for (int n = 1; n <= 3; n++) push_a(t0 + 2 + 4 * n, 190 + n);
        wait_cyc(t0 + 15);
        check("t1b_duty_pre", duty_a, 193);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push_a(cyc, 0);
        #1;
        check("t1b_async_duty", duty_a, 0);
        check("t1b_async_busy", busy_a, 0);
        tgt_a = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t1b_duty_after", duty_a, 0);
        check("t1b_events_done", q_a.size(), 0);

        // 4. STEP=100: 0 -> 255 saturates at 255. 250 -> 0 stops at 0 without wrapping.
        t0 = cyc;
        tgt_b = 8'd255;
        push_b(t0 + 6, 100);
        push_b(t0 + 10, 200);
        push_b(t0 + 14, 255);
        wait_cyc(t0 + 16);
        check("t4_up_duty", duty_b, 255);
        check("t4_up_busy", busy_b, 0);
        t = cyc;
        byp_b = 1'b1;
        tgt_b = 8'd250;
        push_b(t + 2, 250);
        wait_cyc(t + 3);
        byp_b = 1'b0;
        t0 = cyc;
        tgt_b = 8'd0;
        push_b(t0 + 6, 150);
        push_b(t0 + 10, 50);
        push_b(t0 + 14, 0);
        wait_cyc(t0 + 16);
        check("t4_down_duty", duty_b, 0);
        check("t4_down_busy", busy_b, 0);
        check("t4_events_done", q_b.size(), 0);
        check("dut_a_untouched_by_b", duty_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
